msf_time_decoder: RTL

//  Writer side of the digit-chain load interface. Collects per-second MSF symbols (bits A/B),

---
 rtl/msf_pkg.sv | 16 +
 rtl/msf_frame_check.sv | 34 +++
 rtl/msf_time_decoder.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/msf_pkg.sv
// Shared MSF frame constants and decoder state type.
package msf_pkg;

  localparam logic [5:0] MSF_A_HOUR_FIRST  = 6'd39;
  localparam logic [5:0] MSF_A_MIN_LAST    = 6'd51;
  localparam logic [5:0] MSF_A_MARK_FIRST  = 6'd52;
  localparam logic [5:0] MSF_B_TIME_PARITY = 6'd57;
  localparam logic [7:0] MSF_MARKER        = 8'b0111_1110;
  localparam logic [5:0] MSF_LAST_SEC      = 6'd59;

  typedef enum logic {
    UNSYNC,
    COLLECT
  } msf_state_t;

endpackage

// File: rtl/msf_frame_check.sv
// Combinational acceptance check of a collected MSF frame plus BCD field split.
module msf_frame_check
  import msf_pkg::*;
(
  input  logic [12:0] time_i,
  input  logic        parity_i,
  input  logic [7:0]  marker_i,
  input  logic [5:0]  sec_cnt_i,
  input  logic        overrun_i,
  output logic        valid_o,
  output logic [1:0]  hour_msd_o,
  output logic [3:0]  hour_lsd_o,
  output logic [2:0]  min_msd_o,
  output logic [3:0]  min_lsd_o
);

  logic range_ok;
  logic parity_ok;

  // time_i[12] holds A39 (first shifted in); split fields and validate them.
  always_comb begin
    hour_msd_o = time_i[12:11];
    hour_lsd_o = time_i[10:7];
    min_msd_o  = time_i[6:4];
    min_lsd_o  = time_i[3:0];
    range_ok   = (hour_msd_o <= 2'd2) && (hour_lsd_o <= 4'd9) &&
                 !((hour_msd_o == 2'd2) && (hour_lsd_o > 4'd3)) &&
                 (min_msd_o <= 3'd5) && (min_lsd_o <= 4'd9);
    parity_ok  = ^{time_i, parity_i};
    valid_o    = (sec_cnt_i == MSF_LAST_SEC) && !overrun_i &&
                 (marker_i == MSF_MARKER) && parity_ok && range_ok;
  end

endmodule

// File: rtl/msf_time_decoder.sv
// MSF time-of-day decoder: collects one minute of symbols and loads HH:MM:00.
module msf_time_decoder
  import msf_pkg::*;
#(
  parameter int unsigned CONSEC_GOOD = 2
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       minute_i,
  input  logic       sym_valid_i,
  input  logic       sym_a_i,
  input  logic       sym_b_i,
  output logic       load_o,
  output logic [1:0] load_hour_msd_o,
  output logic [3:0] load_hour_lsd_o,
  output logic [2:0] load_min_msd_o,
  output logic [3:0] load_min_lsd_o,
  output logic [2:0] load_sec_msd_o,
  output logic [3:0] load_sec_lsd_o,
  output logic       synced_o,
  output logic       frame_err_o
);

  localparam logic [1:0] GOOD_MAX = 2'(CONSEC_GOOD);

  msf_state_t  state_q, state_d;
  logic [5:0]  sec_cnt_q, sec_cnt_d, sec_next;
  logic        overrun_q, overrun_d;
  logic [12:0] time_q, time_d;
  logic        parity_q, parity_d;
  logic [7:0]  marker_q, marker_d;
  logic [1:0]  good_cnt_q, good_cnt_d, good_inc;
  logic        load_q, load_d;
  logic        frame_err_q, frame_err_d;
  logic        synced_q, synced_d;
  logic [1:0]  hour_msd_q, hour_msd_d;
  logic [3:0]  hour_lsd_q, hour_lsd_d;
  logic [2:0]  min_msd_q, min_msd_d;
  logic [3:0]  min_lsd_q, min_lsd_d;

  logic        fc_valid;
  logic [1:0]  fc_hour_msd;
  logic [3:0]  fc_hour_lsd;
  logic [2:0]  fc_min_msd;
  logic [3:0]  fc_min_lsd;

  msf_frame_check u_frame_check (
    .time_i     (time_q),
    .parity_i   (parity_q),
    .marker_i   (marker_q),
    .sec_cnt_i  (sec_cnt_q),
    .overrun_i  (overrun_q),
    .valid_o    (fc_valid),
    .hour_msd_o (fc_hour_msd),
    .hour_lsd_o (fc_hour_lsd),
    .min_msd_o  (fc_min_msd),
    .min_lsd_o  (fc_min_lsd)
  );

  // Next-state: symbol collection, frame verdict at the minute marker, output loads.
  always_comb begin
    state_d     = state_q;
    sec_cnt_d   = sec_cnt_q;
    overrun_d   = overrun_q;
    time_d      = time_q;
    parity_d    = parity_q;
    marker_d    = marker_q;
    good_cnt_d  = good_cnt_q;
    synced_d    = synced_q;
    hour_msd_d  = hour_msd_q;
    hour_lsd_d  = hour_lsd_q;
    min_msd_d   = min_msd_q;
    min_lsd_d   = min_lsd_q;
    load_d      = 1'b0;
    frame_err_d = 1'b0;
    sec_next    = sec_cnt_q + 6'd1;
    good_inc    = (good_cnt_q >= GOOD_MAX) ? GOOD_MAX : good_cnt_q + 2'd1;

    case (state_q)
      UNSYNC: begin
        if (minute_i) begin
          state_d   = COLLECT;
          sec_cnt_d = '0;
          overrun_d = 1'b0;
          time_d    = '0;
          parity_d  = 1'b0;
          marker_d  = '0;
        end
      end
      COLLECT: begin
        // minute_i takes priority so a coincident symbol is dropped.
        if (minute_i) begin
          if (fc_valid) begin
            good_cnt_d = good_inc;
            if (good_inc == GOOD_MAX) begin
              load_d     = 1'b1;
              synced_d   = 1'b1;
              hour_msd_d = fc_hour_msd;
              hour_lsd_d = fc_hour_lsd;
              min_msd_d  = fc_min_msd;
              min_lsd_d  = fc_min_lsd;
            end
          end else begin
            good_cnt_d  = '0;
            synced_d    = 1'b0;
            frame_err_d = 1'b1;
          end
          sec_cnt_d = '0;
          overrun_d = 1'b0;
          time_d    = '0;
          parity_d  = 1'b0;
          marker_d  = '0;
        end else if (sym_valid_i) begin
          if (sec_cnt_q == MSF_LAST_SEC) begin
            overrun_d = 1'b1;
          end else begin
            sec_cnt_d = sec_next;
            if ((sec_next >= MSF_A_HOUR_FIRST) && (sec_next <= MSF_A_MIN_LAST))
              time_d = {time_q[11:0], sym_a_i};
            if (sec_next == MSF_B_TIME_PARITY)
              parity_d = sym_b_i;
            if (sec_next >= MSF_A_MARK_FIRST)
              marker_d = {marker_q[6:0], sym_a_i};
          end
        end
      end
      default: state_d = UNSYNC;
    endcase
  end

  // State and output registers; reset clears everything including held load values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= UNSYNC;
      sec_cnt_q   <= '0;
      overrun_q   <= 1'b0;
      time_q      <= '0;
      parity_q    <= 1'b0;
      marker_q    <= '0;
      good_cnt_q  <= '0;
      load_q      <= 1'b0;
      frame_err_q <= 1'b0;
      synced_q    <= 1'b0;
      hour_msd_q  <= '0;
      hour_lsd_q  <= '0;
      min_msd_q   <= '0;
      min_lsd_q   <= '0;
    end else begin
      state_q     <= state_d;
      sec_cnt_q   <= sec_cnt_d;
      overrun_q   <= overrun_d;
      time_q      <= time_d;
      parity_q    <= parity_d;
      marker_q    <= marker_d;
      good_cnt_q  <= good_cnt_d;
      load_q      <= load_d;
      frame_err_q <= frame_err_d;
      synced_q    <= synced_d;
      hour_msd_q  <= hour_msd_d;
      hour_lsd_q  <= hour_lsd_d;
      min_msd_q   <= min_msd_d;
      min_lsd_q   <= min_lsd_d;
    end
  end

  assign load_o          = load_q;
  assign frame_err_o     = frame_err_q;
  assign synced_o        = synced_q;
  assign load_hour_msd_o = hour_msd_q;
  assign load_hour_lsd_o = hour_lsd_q;
  assign load_min_msd_o  = min_msd_q;
  assign load_min_lsd_o  = min_lsd_q;
  assign load_sec_msd_o  = '0;
  assign load_sec_lsd_o  = '0;

endmodule
